// File: rtl/dyno_sprite_sequencer_if.sv
// Pixel lookup port between the VGA renderer (master) and the dyno sprite sequencer (slave).
interface dyno_sprite_sequencer_if;
    logic [4:0]  px;
    logic [4:0]  py;
    logic        px_req;
    logic [23:0] pix_rgb;
    logic        pix_valid;
    logic        pix_opaque;

    modport master (
        output px, py, px_req,
        input  pix_rgb, pix_valid, pix_opaque
    );

    modport slave (
        input  px, py, px_req,
        output pix_rgb, pix_valid, pix_opaque
    );
endinterface

// File: rtl/dyno_sprite_sequencer.sv
// Dyno animation controller: pose FSM, 2-phase animation counter and registered sprite pixel lookup.
// Optional death blink (pix_opaque forced low on alternate periods in DEAD) under `DYNO_DEATH_BLINK_EN.
module dyno_sprite_sequencer #(
    parameter int unsigned ANIM_PERIOD = 6,
    parameter logic [23:0] TRANSP_RGB  = 24'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick_i,
    input  logic                 duck_i,
    input  logic                 airborne_i,
    input  logic                 game_over_i,
    input  logic                 restart_i,
    input  logic [31:0][23:0]    run1_i  [0:31],
    input  logic [31:0][23:0]    run2_i  [0:31],
    input  logic [31:0][23:0]    duck1_i [0:31],
    input  logic [31:0][23:0]    duck2_i [0:31],
    dyno_sprite_sequencer_if.slave pix_if,
    output logic [1:0]           pose_o,
    output logic                 phase_o
);

    typedef enum logic [1:0] {
        POSE_RUN  = 2'b00,
        POSE_DUCK = 2'b01,
        POSE_JUMP = 2'b10,
        POSE_DEAD = 2'b11
    } pose_e;

    localparam logic [7:0] LAST_COUNT = 8'(ANIM_PERIOD - 1);

    pose_e       pose_q, pose_d;
    logic [7:0]  count_q, count_d;
    logic        phase_q, phase_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic        pix_opaque_q, pix_opaque_d;
    logic [23:0] sel_pix;
    logic        pose_change;
    logic        hide_pix;

    // Pose next-state: game_over dominates restart, DEAD ignores the movement inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pose_d = pose_q;
        if (game_over_i) begin
            pose_d = POSE_DEAD;
        end else if (pose_q == POSE_DEAD) begin
            if (restart_i) pose_d = POSE_RUN;
        end else if (airborne_i) begin
            pose_d = POSE_JUMP;
        end else if (duck_i) begin
            pose_d = POSE_DUCK;
        end else begin
            pose_d = POSE_RUN;
        end
    end

    assign pose_change = (pose_d != pose_q);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (pose_change) begin
            count_d = 8'd0;
            phase_d = 1'b0;
        end else if (frame_tick_i && (pose_q == POSE_RUN || pose_q == POSE_DUCK)) begin
            if (count_q == LAST_COUNT) begin
                count_d = 8'd0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

`ifdef DYNO_DEATH_BLINK_EN
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_q, blink_d;

    // Blink restarts from 0 on every entry into DEAD because entry is a pose change.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (pose_change) begin
            blink_cnt_d = 8'd0;
            blink_d     = 1'b0;
        end else if (frame_tick_i && pose_q == POSE_DEAD) begin
            if (blink_cnt_q == LAST_COUNT) begin
                blink_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign hide_pix = blink_q;
`else
    assign hide_pix = 1'b0;
`endif

    // Image choice uses the already-registered pose/phase, so a lookup sees the state from the previous edge.
    always_comb begin
        sel_pix = run1_i[pix_if.px][pix_if.py];
        case (pose_q)
            POSE_RUN:  sel_pix = phase_q ? run2_i[pix_if.px][pix_if.py]
                                         : run1_i[pix_if.px][pix_if.py];
            POSE_DUCK: sel_pix = phase_q ? duck2_i[pix_if.px][pix_if.py]
                                         : duck1_i[pix_if.px][pix_if.py];
            default:   sel_pix = run1_i[pix_if.px][pix_if.py];
        endcase
    end

    always_comb begin
        pix_valid_d  = pix_if.px_req;
        pix_rgb_d    = pix_rgb_q;
        pix_opaque_d = pix_opaque_q;
        if (pix_if.px_req) begin
            pix_rgb_d    = sel_pix;
            pix_opaque_d = (sel_pix != TRANSP_RGB) && !hide_pix;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pose_q       <= POSE_RUN;
            count_q      <= 8'd0;
            phase_q      <= 1'b0;
            pix_rgb_q    <= 24'd0;
            pix_valid_q  <= 1'b0;
            pix_opaque_q <= 1'b0;
        end else begin
            pose_q       <= pose_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_valid_q  <= pix_valid_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    assign pose_o            = pose_q;
    assign phase_o           = phase_q;
    assign pix_if.pix_rgb    = pix_rgb_q;
    assign pix_if.pix_valid  = pix_valid_q;
    assign pix_if.pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_dyno_sprite_sequencer.sv
// Directed bench for dyno_sprite_sequencer: reset, phase stepping, duck/jump, death/restart, streaming lookups.
module tb_dyno_sprite_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick, duck, airborne, game_over, restart;
    logic [31:0][23:0] run1  [0:31];
    logic [31:0][23:0] run2  [0:31];
    logic [31:0][23:0] duck1 [0:31];
    logic [31:0][23:0] duck2 [0:31];
    logic [1:0] pose;
    logic       phase;

    int n_vec = 0;
    int n_err = 0;

    dyno_sprite_sequencer_if pix_if ();

    dyno_sprite_sequencer #(.ANIM_PERIOD(6), .TRANSP_RGB(24'd0)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .duck_i       (duck),
        .airborne_i   (airborne),
        .game_over_i  (game_over),
        .restart_i    (restart),
        .run1_i       (run1),
        .run2_i       (run2),
        .duck1_i      (duck1),
        .duck2_i      (duck2),
        .pix_if       (pix_if),
        .pose_o       (pose),
        .phase_o      (phase)
    );

    always #5 clk = ~clk;

    // Image content: {tag, x, y}; pixel (5,7) of every image is transparent black.
    function automatic logic [23:0] exp_pix(input logic [7:0] tag, input int x, input int y);
        if (x == 5 && y == 7) return 24'd0;
        return {tag, 8'(x), 8'(y)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic lookup(input int x, input int y);
        pix_if.px     = 5'(x);
        pix_if.py     = 5'(y);
        pix_if.px_req = 1'b1;
        step();
        pix_if.px_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_if.px = 5'd3; pix_if.py = 5'd3; pix_if.px_req = 1'b1;
        step(); step();
        pix_if.px_req = 1'b0;
        step();
        n_vec++; if (pose !== 2'b00) begin n_err++; $display("FAIL reset_pose: got %b want 00", pose); end
        n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL reset_phase: got %b want 0", phase); end
        n_vec++; if (pix_if.pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pix_if.pix_valid); end
        n_vec++; if (pix_if.pix_rgb !== 24'd0) begin n_err++; $display("FAIL reset_rgb: got %h want 000000", pix_if.pix_rgb); end
        n_vec++; if (pix_if.pix_opaque !== 1'b0) begin n_err++; $display("FAIL reset_opaque: got %b want 0", pix_if.pix_opaque); end
        reset = 1'b0;
        lookup(0, 0);
        n_vec++; if (pix_if.pix_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", pix_if.pix_valid); end
        n_vec++; if (pix_if.pix_rgb !== 24'h110000) begin n_err++; $display("FAIL first_rgb: got %h want 110000", pix_if.pix_rgb); end
        n_vec++; if (pix_if.pix_opaque !== 1'b1) begin n_err++; $display("FAIL first_opaque: got %b want 1", pix_if.pix_opaque); end
        n_vec++; if (pose !== 2'b00 || phase !== 1'b0) begin n_err++; $display("FAIL first_pose: got %b/%b want 00/0", pose, phase); end
        step();
        n_vec++; if (pix_if.pix_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", pix_if.pix_valid); end
    endtask

    task automatic test_phase();
        tick(5);
        n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL phase_5ticks: got %b want 0", phase); end
        tick(1);
        n_vec++; if (phase !== 1'b1) begin n_err++; $display("FAIL phase_6ticks: got %b want 1", phase); end
        lookup(2, 3);
        n_vec++; if (pix_if.pix_rgb !== 24'h220203 || pix_if.pix_valid !== 1'b1) begin
            n_err++; $display("FAIL run2_pix: got %h/%b want 220203/1", pix_if.pix_rgb, pix_if.pix_valid); end
        tick(6);
        n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL phase_12ticks: got %b want 0", phase); end
        lookup(5, 7);
        n_vec++; if (pix_if.pix_rgb !== 24'd0 || pix_if.pix_opaque !== 1'b0 || pix_if.pix_valid !== 1'b1) begin
            n_err++; $display("FAIL transp_pix: got %h/%b/%b want 000000/0/1", pix_if.pix_rgb, pix_if.pix_opaque, pix_if.pix_valid); end
    endtask

    task automatic test_duck_jump();
        tick(6);
        n_vec++; if (phase !== 1'b1) begin n_err++; $display("FAIL pre_duck_phase: got %b want 1", phase); end
        duck = 1'b1;
        step();
        n_vec++; if (pose !== 2'b01 || phase !== 1'b0) begin n_err++; $display("FAIL duck_enter: got %b/%b want 01/0", pose, phase); end
        lookup(1, 2);
        n_vec++; if (pix_if.pix_rgb !== 24'h330102) begin n_err++; $display("FAIL duck1_pix: got %h want 330102", pix_if.pix_rgb); end
        tick(6);
        lookup(4, 4);
        n_vec++; if (pix_if.pix_rgb !== 24'h440404) begin n_err++; $display("FAIL duck2_pix: got %h want 440404", pix_if.pix_rgb); end
        airborne = 1'b1;
        step();
        n_vec++; if (pose !== 2'b10 || phase !== 1'b0) begin n_err++; $display("FAIL jump_enter: got %b/%b want 10/0", pose, phase); end
        tick(6);
        n_vec++; if (pose !== 2'b10 || phase !== 1'b0) begin n_err++; $display("FAIL jump_frozen: got %b/%b want 10/0", pose, phase); end
        lookup(3, 3);
        n_vec++; if (pix_if.pix_rgb !== 24'h110303) begin n_err++; $display("FAIL jump_pix: got %h want 110303", pix_if.pix_rgb); end
        airborne = 1'b0;
        step();
        n_vec++; if (pose !== 2'b01) begin n_err++; $display("FAIL land_duck: got %b want 01", pose); end
        duck = 1'b0;
        step();
        n_vec++; if (pose !== 2'b00) begin n_err++; $display("FAIL back_run: got %b want 00", pose); end
    endtask

    task automatic test_dead();
        logic blink_opaque;
`ifdef DYNO_DEATH_BLINK_EN
        blink_opaque = 1'b0;
`else
        blink_opaque = 1'b1;
`endif
        tick(3);
        game_over = 1'b1; restart = 1'b1;
        step();
        game_over = 1'b0; restart = 1'b0;
        n_vec++; if (pose !== 2'b11 || phase !== 1'b0) begin n_err++; $display("FAIL dead_enter: got %b/%b want 11/0", pose, phase); end
        lookup(6, 6);
        n_vec++; if (pix_if.pix_rgb !== 24'h110606 || pix_if.pix_opaque !== 1'b1) begin
            n_err++; $display("FAIL dead_pix: got %h/%b want 110606/1", pix_if.pix_rgb, pix_if.pix_opaque); end
        tick(6);
        lookup(6, 6);
        n_vec++; if (pix_if.pix_rgb !== 24'h110606 || pix_if.pix_opaque !== blink_opaque) begin
            n_err++; $display("FAIL blink_on: got %h/%b want 110606/%b", pix_if.pix_rgb, pix_if.pix_opaque, blink_opaque); end
        lookup(2, 2);
        n_vec++; if (pix_if.pix_rgb !== 24'h110202 || pix_if.pix_opaque !== blink_opaque) begin
            n_err++; $display("FAIL blink_on2: got %h/%b want 110202/%b", pix_if.pix_rgb, pix_if.pix_opaque, blink_opaque); end
        tick(6);
        lookup(6, 6);
        n_vec++; if (pix_if.pix_opaque !== 1'b1) begin n_err++; $display("FAIL blink_off: got %b want 1", pix_if.pix_opaque); end
        duck = 1'b1; airborne = 1'b1;
        step();
        duck = 1'b0; airborne = 1'b0;
        n_vec++; if (pose !== 2'b11) begin n_err++; $display("FAIL dead_hold: got %b want 11", pose); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_vec++; if (pose !== 2'b00 || phase !== 1'b0) begin n_err++; $display("FAIL restart: got %b/%b want 00/0", pose, phase); end
        tick(5);
        n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL restart_count5: got %b want 0", phase); end
        tick(1);
        n_vec++; if (phase !== 1'b1) begin n_err++; $display("FAIL restart_count6: got %b want 1", phase); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] want;
        reset = 1'b1;
        step();
        reset = 1'b0;
        pix_if.py     = 5'd9;
        pix_if.px_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pix_if.px = 5'(i);
            step();
            want = exp_pix(8'h11, i, 9);
            n_vec++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_rgb !== want) begin
                n_err++; $display("FAIL sweep_%0d: got %h/%b want %h/1", i, pix_if.pix_rgb, pix_if.pix_valid, want); end
        end
        pix_if.px_req = 1'b0;
        step();
        n_vec++; if (pix_if.pix_valid !== 1'b0 || pix_if.pix_rgb !== 24'h111f09) begin
            n_err++; $display("FAIL sweep_hold: got %h/%b want 111f09/0", pix_if.pix_rgb, pix_if.pix_valid); end
        pix_if.px_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_if.px = 5'(i);
            step();
        end
        n_vec++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_rgb !== 24'h110309) begin
            n_err++; $display("FAIL presweep: got %h/%b want 110309/1", pix_if.pix_rgb, pix_if.pix_valid); end
        pix_if.px = 5'd4;
        reset = 1'b1;
        step();
        n_vec++; if (pix_if.pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", pix_if.pix_valid); end
        reset = 1'b0;
        pix_if.px_req = 1'b0;
        step();
        n_vec++; if (pix_if.pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_after: got %b want 0", pix_if.pix_valid); end
    endtask

    initial begin
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                run1[x][y]  = exp_pix(8'h11, x, y);
                run2[x][y]  = exp_pix(8'h22, x, y);
                duck1[x][y] = exp_pix(8'h33, x, y);
                duck2[x][y] = exp_pix(8'h44, x, y);
            end
        end
        reset = 1'b1;
        frame_tick = 1'b0; duck = 1'b0; airborne = 1'b0; game_over = 1'b0; restart = 1'b0;
        pix_if.px = 5'd0; pix_if.py = 5'd0; pix_if.px_req = 1'b0;

        test_reset();
        test_phase();
        test_duck_jump();
        test_dead();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
